// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and default kernel for the 3x3 convolution MAC.
// Contents: DATA_W, COEF_W, ACC_W widths, tap count, state_e, default Gaussian kernel.
package cnn_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned NTAPS  = 9;
  localparam int unsigned TAP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Gaussian 1,2,1 / 2,4,2 / 1,2,1; tap 0 sits in the least significant byte.
  localparam logic [NTAPS*COEF_W-1:0] DEF_KERNEL = {
    8'd1, 8'd2, 8'd1,
    8'd2, 8'd4, 8'd2,
    8'd1, 8'd2, 8'd1
  };

  function automatic logic signed [COEF_W-1:0] def_coef(input int k);
    return $signed(DEF_KERNEL[k*COEF_W +: COEF_W]);
  endfunction

endpackage

// File: rtl/mac_channel.sv
// One colour channel: unsigned 8-bit pixel x signed coefficient, 20-bit accumulate,
// round-half-up arithmetic shift and clamp to 0..255.
// Ports: iClk/iRst clock and async reset; iClr clears the accumulator; iEn adds one
// product; iPix/iCoef are the current tap operands; oRes_c is the saturated result
// taken combinationally from the accumulator.
module mac_channel #(
  parameter int unsigned COEF_W = cnn_pkg::COEF_W,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iClr,
  input  logic                     iEn,
  input  logic [7:0]               iPix,
  input  logic signed [COEF_W-1:0] iCoef,
  output logic [7:0]               oRes_c
);
  import cnn_pkg::*;

  localparam int unsigned PROD_W = COEF_W + 9;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT - 1));

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shf;

  // Zero-extend the pixel into a signed operand so the product keeps its sign.
  assign prod = PROD_W'($signed({1'b0, iPix})) * PROD_W'(iCoef);

  always_comb begin
    acc_d = acc_q;
    if (iClr) begin
      acc_d = '0;
    end else if (iEn) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rnd = acc_q + RND;
  assign shf = rnd >>> SHIFT;

  // Negative results clamp to 0, anything above 8 bits clamps to 255.
  always_comb begin
    oRes_c = shf[7:0];
    if (shf[ACC_W-1]) begin
      oRes_c = 8'h00;
    end else if (|shf[ACC_W-2:8]) begin
      oRes_c = 8'hFF;
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 RGB888 convolution: latches a window, runs nine MAC taps on three
// channel engines, rounds/saturates, and holds the result until accepted.
// Ports: iClk/iRst; iIn0..iIn8 window (row-major) with iValid capture pulse; oBusy
// while a window is in flight; iCoefWe/iCoefAddr/iCoefData kernel writes (IDLE only);
// oPixel/oValid result with iReady accept; oDrop sticky lost-window flag.
module conv3x3_mac #(
  parameter int unsigned DATA_W = cnn_pkg::DATA_W,
  parameter int unsigned COEF_W = cnn_pkg::COEF_W,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [DATA_W-1:0]        iIn0,
  input  logic [DATA_W-1:0]        iIn1,
  input  logic [DATA_W-1:0]        iIn2,
  input  logic [DATA_W-1:0]        iIn3,
  input  logic [DATA_W-1:0]        iIn4,
  input  logic [DATA_W-1:0]        iIn5,
  input  logic [DATA_W-1:0]        iIn6,
  input  logic [DATA_W-1:0]        iIn7,
  input  logic [DATA_W-1:0]        iIn8,
  input  logic                     iValid,
  output logic                     oBusy,
  input  logic                     iCoefWe,
  input  logic [3:0]               iCoefAddr,
  input  logic signed [COEF_W-1:0] iCoefData,
  output logic [DATA_W-1:0]        oPixel,
  output logic                     oValid,
  input  logic                     iReady,
  output logic                     oDrop
);
  import cnn_pkg::*;

  state_e                   state_q, state_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [DATA_W-1:0]        win_q [NTAPS];
  logic [DATA_W-1:0]        win_d [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic [DATA_W-1:0]        pix_q, pix_d;
  logic                     valid_q, valid_d;
  logic                     drop_q, drop_d;

  logic [DATA_W-1:0]        in_w [NTAPS];
  logic [DATA_W-1:0]        cur_win;
  logic signed [COEF_W-1:0] cur_coef;
  logic [7:0]               ch_res [3];
  logic [DATA_W-1:0]        sat_pix;
  logic                     capture;

  assign in_w     = '{iIn0, iIn1, iIn2, iIn3, iIn4, iIn5, iIn6, iIn7, iIn8};
  assign capture  = (state_q == ST_IDLE) && iValid;
  assign cur_win  = win_q[tap_q];
  assign cur_coef = coef_q[tap_q];
  assign sat_pix  = DATA_W'({ch_res[2], ch_res[1], ch_res[0]});

  // Channel 0 = B, 1 = G, 2 = R.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    mac_channel #(
      .COEF_W (COEF_W),
      .SHIFT  (SHIFT)
    ) u_mac (
      .iClk   (iClk),
      .iRst   (iRst),
      .iClr   (capture),
      .iEn    (state_q == ST_MAC),
      .iPix   (cur_win[8*c +: 8]),
      .iCoef  (cur_coef),
      .oRes_c (ch_res[c])
    );
  end

  // Next-state logic; kernel writes land only in IDLE and lose to a same-edge capture.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    win_d   = win_q;
    coef_d  = coef_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    drop_d  = drop_q;

    if (iValid && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          win_d   = in_w;
          tap_d   = '0;
          state_d = ST_MAC;
        end else if (iCoefWe && (iCoefAddr < TAP_W'(NTAPS))) begin
          coef_d[iCoefAddr] = iCoefData;
        end
      end
      ST_MAC: begin
        if (tap_q == TAP_W'(NTAPS - 1)) begin
          tap_d   = '0;
          state_d = ST_SAT;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ST_SAT: begin
        pix_d   = sat_pix;
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      for (int k = 0; k < int'(NTAPS); k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= COEF_W'(def_coef(k));
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      win_q   <= win_d;
      coef_q  <= coef_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign oBusy  = (state_q != ST_IDLE);
  assign oPixel = pix_q;
  assign oValid = valid_q;
  assign oDrop  = drop_q;

endmodule
